sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 38 +++
 rtl/sram_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, data port and shared Sram port signals.
// The arbiter takes the slave view; requesters and the Sram take the master view.
interface sram_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_mem;

    logic        sram_read;
    logic        sram_write;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        output if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
        output stall_if, stall_mem, sram_read, sram_write, sram_addr, sram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        input  if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
        input  stall_if, stall_mem, sram_read, sram_write, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle-latency Sram port.
// Data port has priority; fetch is forced through after STARVE_MAX consecutive losses.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst_n,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {RespNone, RespIf, RespMemRd, RespMemWr} resp_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    resp_e      resp_q, resp_d;
    logic [3:0] starve_q, starve_d;
    logic       if_win, mem_win, mem_wr_win;

    // Grants are forced low while in reset so nothing reaches the Sram.
    always_comb begin
        mem_win    = rst_n & bus.mem_req & ~(bus.if_req & (starve_q == StarveMax));
        if_win     = rst_n & bus.if_req & ~mem_win;
        mem_wr_win = mem_win & bus.mem_we;
    end

    always_comb begin
        bus.if_gnt     = if_win;
        bus.mem_gnt    = mem_win;
        bus.stall_if   = rst_n & bus.if_req & ~if_win;
        bus.stall_mem  = rst_n & bus.mem_req & ~mem_win;
        bus.sram_read  = if_win | (mem_win & ~bus.mem_we);
        bus.sram_write = mem_wr_win;
        bus.sram_addr  = '0;
        if (if_win) begin
            bus.sram_addr = bus.if_addr;
        end else if (mem_win) begin
            bus.sram_addr = bus.mem_addr;
        end
        bus.sram_wdata = mem_wr_win ? bus.mem_wdata : '0;
    end

    always_comb begin
        resp_d = RespNone;
        if (if_win) begin
            resp_d = RespIf;
        end else if (mem_wr_win) begin
            resp_d = RespMemWr;
        end else if (mem_win) begin
            resp_d = RespMemRd;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || if_win) begin
            starve_d = '0;
        end else if (mem_win && (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_q   <= RespNone;
            starve_q <= '0;
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
        end
    end

    // Responses are gated by reset so a stale owner never leaks out during reset.
    always_comb begin
        bus.if_valid  = rst_n && (resp_q == RespIf);
        bus.mem_valid = rst_n && ((resp_q == RespMemRd) || (resp_q == RespMemWr));
        bus.if_rdata  = bus.if_valid ? bus.sram_rdata : '0;
        bus.mem_rdata = (rst_n && (resp_q == RespMemRd)) ? bus.sram_rdata : '0;
    end

endmodule
